// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares the single 32-bit word interface of the async SRAM controller between
// the CPU data port and the video scanout prefetch port. Each port holds one
// latched request. Video is granted first. A CPU anti-starvation streak limit
// overrides that after STARVE_LIMIT consecutive video grants. Exactly one
// controller transaction is in flight at a time. Read data and completion are
// routed back to the port that owns the transaction.
//
// Parameters:
//   STARVE_LIMIT  max consecutive video grants while CPU waits (1..15)
//   ADDR_W        word address width
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_data/cpu_wstrb
//                                      CPU request pulse and payload
//   cpu_q/cpu_busy/cpu_q_valid         CPU read data, busy, read strobe
//   vid_rd/vid_addr                    video read request pulse and address
//   vid_q/vid_busy/vid_q_valid         video read data, busy, read strobe
//   mem_rd/mem_wr/mem_addr/mem_data/mem_wstrb
//                                      request to the SRAM controller
//   mem_busy/mem_q/mem_q_valid         controller status and read data
//   dbg_cpu_grants/dbg_vid_grants      grant counters
//
// Build option:
//   SRAM_ARB_STATS_EN  when defined, the dbg_* outputs are 16-bit wrapping
//                      grant counters. Otherwise they are tied to 0.
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 22
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_data,
    input  logic [3:0]        cpu_wstrb,
    output logic [31:0]       cpu_q,
    output logic              cpu_busy,
    output logic              cpu_q_valid,
    input  logic              vid_rd,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [31:0]       vid_q,
    output logic              vid_busy,
    output logic              vid_q_valid,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_busy,
    input  logic [31:0]       mem_q,
    input  logic              mem_q_valid,
    output logic [15:0]       dbg_cpu_grants,
    output logic [15:0]       dbg_vid_grants
);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_ACK,
        ARB_DONE
    } arb_state_t;

    arb_state_t r_state, w_next;

    // per-port request latches
    logic              r_cpu_pend, r_vid_pend;
    logic [ADDR_W-1:0] r_cpu_addr, r_vid_addr;
    logic [31:0]       r_cpu_data;
    logic [3:0]        r_cpu_wstrb;
    logic              r_cpu_wr;

    // transaction in flight
    logic              r_owner_vid;
    logic              r_is_wr;
    logic [3:0]        r_streak;
    logic              r_mem_rd, r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_data;
    logic [3:0]        r_mem_wstrb;

    // return path
    logic [31:0]       r_cpu_q, r_vid_q;
    logic              r_cpu_qv, r_vid_qv;

    logic              w_cpu_cap, w_vid_cap;
    logic              w_cpu_req, w_vid_req;
    logic              w_gnt_cpu, w_gnt_vid;
    logic              w_issue, w_done, w_finish;
    logic [ADDR_W-1:0] w_cpu_addr_e, w_vid_addr_e;
    logic [31:0]       w_cpu_data_e;
    logic [3:0]        w_cpu_wstrb_e;
    logic              w_cpu_wr_e;

    // A pulse is accepted only while the port has nothing latched.
    assign w_cpu_cap = (cpu_rd | cpu_wr) & ~r_cpu_pend;
    assign w_vid_cap = vid_rd & ~r_vid_pend;

    // A pulse that arrives while idle competes in the same cycle as latched
    // requests. A port that re-requests immediately after its completion
    // therefore still counts as pending. Without this, the other port would
    // always win the idle cycle and the streak limit could never take effect.
    assign w_cpu_req     = r_cpu_pend | w_cpu_cap;
    assign w_vid_req     = r_vid_pend | w_vid_cap;
    assign w_cpu_addr_e  = r_cpu_pend ? r_cpu_addr  : cpu_addr;
    assign w_cpu_data_e  = r_cpu_pend ? r_cpu_data  : cpu_data;
    assign w_cpu_wstrb_e = r_cpu_pend ? r_cpu_wstrb : cpu_wstrb;
    assign w_cpu_wr_e    = r_cpu_pend ? r_cpu_wr    : cpu_wr;
    assign w_vid_addr_e  = r_vid_pend ? r_vid_addr  : vid_addr;

    // mem_busy falls together with mem_q_valid on reads
    assign w_done   = ~mem_busy & (r_is_wr | mem_q_valid);
    assign w_finish = (r_state == ARB_DONE) & w_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ARB_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_gnt_cpu = 1'b0;
        w_gnt_vid = 1'b0;
        w_issue   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_vid_req && (!w_cpu_req || r_streak < 4'(STARVE_LIMIT)))
                    w_gnt_vid = 1'b1;
                else if (w_cpu_req)
                    w_gnt_cpu = 1'b1;
                if (w_gnt_vid || w_gnt_cpu) w_next = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                if (!mem_busy) begin
                    w_issue = 1'b1;
                    w_next  = ARB_ACK;
                end
            end
            ARB_ACK:  if (mem_busy) w_next = ARB_DONE;
            ARB_DONE: if (w_done)   w_next = ARB_IDLE;
            default:  w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_pend  <= 1'b0;
            r_vid_pend  <= 1'b0;
            r_cpu_addr  <= '0;
            r_vid_addr  <= '0;
            r_cpu_data  <= '0;
            r_cpu_wstrb <= '0;
            r_cpu_wr    <= 1'b0;
            r_owner_vid <= 1'b0;
            r_is_wr     <= 1'b0;
            r_streak    <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_wstrb <= '0;
            r_cpu_q     <= '0;
            r_vid_q     <= '0;
            r_cpu_qv    <= 1'b0;
            r_vid_qv    <= 1'b0;
        end else begin
            // capture. A set and a clear cannot coincide, because capture
            // needs the flag low and a clear needs it high.
            if (w_cpu_cap) begin
                r_cpu_pend  <= 1'b1;
                r_cpu_addr  <= cpu_addr;
                r_cpu_data  <= cpu_data;
                r_cpu_wstrb <= cpu_wstrb;
                r_cpu_wr    <= cpu_wr;    // rd+wr together counts as a write
            end else if (w_finish && !r_owner_vid) begin
                r_cpu_pend <= 1'b0;
            end

            if (w_vid_cap) begin
                r_vid_pend <= 1'b1;
                r_vid_addr <= vid_addr;
            end else if (w_finish && r_owner_vid) begin
                r_vid_pend <= 1'b0;
            end

            // grant: load the controller payload, held until the next grant
            if (w_gnt_cpu) begin
                r_owner_vid <= 1'b0;
                r_is_wr     <= w_cpu_wr_e;
                r_mem_addr  <= w_cpu_addr_e;
                r_mem_data  <= w_cpu_data_e;
                r_mem_wstrb <= w_cpu_wstrb_e;
                r_streak    <= '0;
            end else if (w_gnt_vid) begin
                r_owner_vid <= 1'b1;
                r_is_wr     <= 1'b0;
                r_mem_addr  <= w_vid_addr_e;
                r_mem_data  <= '0;
                r_mem_wstrb <= '0;
                if (!w_cpu_req)             r_streak <= '0;
                else if (r_streak != 4'hF)  r_streak <= r_streak + 4'd1;
            end

            r_mem_rd <= w_issue & ~r_is_wr;
            r_mem_wr <= w_issue &  r_is_wr;

            // return path: a one-cycle strobe; q holds until the next read
            r_cpu_qv <= 1'b0;
            r_vid_qv <= 1'b0;
            if (w_finish && !r_is_wr) begin
                if (r_owner_vid) begin
                    r_vid_q  <= mem_q;
                    r_vid_qv <= 1'b1;
                end else begin
                    r_cpu_q  <= mem_q;
                    r_cpu_qv <= 1'b1;
                end
            end
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] r_cpu_grants, r_vid_grants;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpu_grants <= '0;
            r_vid_grants <= '0;
        end else begin
            if (w_gnt_cpu) r_cpu_grants <= r_cpu_grants + 16'd1;
            if (w_gnt_vid) r_vid_grants <= r_vid_grants + 16'd1;
        end
    end

    assign dbg_cpu_grants = r_cpu_grants;
    assign dbg_vid_grants = r_vid_grants;
`else
    assign dbg_cpu_grants = '0;
    assign dbg_vid_grants = '0;
`endif

    assign cpu_q       = r_cpu_q;
    assign cpu_busy    = r_cpu_pend;
    assign cpu_q_valid = r_cpu_qv;
    assign vid_q       = r_vid_q;
    assign vid_busy    = r_vid_pend;
    assign vid_q_valid = r_vid_qv;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_data    = r_mem_data;
    assign mem_wstrb   = r_mem_wstrb;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter sharing the single 32-bit word interface of the external async SRAM controller between the CPU data port and the video scanout prefetch port.
- Sits between the CPU/video bus adapters and the SRAM controller.
- Latches one request per port, grants by video-first priority with a CPU anti-starvation limit, and issues exactly one controller transaction at a time.
- Routes read data and completion back to the owning port.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive video grants while a CPU request is pending; the next grant goes to the CPU (range 1..15).
- ADDR_W, 22: word address width on all ports.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_rd / cpu_wr  in  1 each  single-cycle request pulses, mutually exclusive
- cpu_addr  in  ADDR_W  word address
- cpu_data  in  32  write data
- cpu_wstrb  in  4  byte write strobes
- cpu_q  out  32  read data
- cpu_busy  out  1  request pending or in flight
- cpu_q_valid  out  1  one-cycle read-data strobe
- vid_rd  in  1  single-cycle read pulse (video is read-only)
- vid_addr  in  ADDR_W  word address
- vid_q  out  32  read data
- vid_busy  out  1  request pending or in flight
- vid_q_valid  out  1  one-cycle read-data strobe
- mem_rd / mem_wr  out  1 each  request pulses to the controller
- mem_addr  out  ADDR_W  word address to the controller
- mem_data  out  32  write data to the controller
- mem_wstrb  out  4  byte strobes to the controller
- mem_busy  in  1  controller busy
- mem_q  in  32  controller read data
- mem_q_valid  in  1  controller read-data strobe
- dbg_cpu_grants  out  16  CPU grant count (feature-dependent)
- dbg_vid_grants  out  16  video grant count (feature-dependent)

Behaviour:
- Reset: every output 0; pending flags cleared; state ARB_IDLE; streak counter 0. Reset mid-transaction abandons it; no q_valid is produced.
- Request capture:
  - A pulse on a port whose busy is low sets that port's pending flag and latches addr/data/wstrb/is_write.
  - Busy rises on the next edge and stays high until the edge that issues that port's q_valid (read) or the completion edge (write).
  - Pulses while busy is high are ignored. Requesters must not pulse in the cycle right after their own pulse.
  - cpu_rd and cpu_wr both high is treated as a write.
- State machine:
  - ARB_IDLE:
    - Only one port pending: grant it.
    - Both pending: grant video unless streak >= STARVE_LIMIT, then grant CPU.
    - On grant: drive mem_addr/mem_data/mem_wstrb from the granted port's latch, go to ARB_ISSUE.
  - ARB_ISSUE: if mem_busy is 0, pulse mem_rd or mem_wr for exactly one cycle, go to ARB_ACK; otherwise wait.
  - ARB_ACK: wait for mem_busy == 1, go to ARB_DONE.
  - ARB_DONE: wait for mem_busy == 0, which coincides with mem_q_valid for reads.
    - Read: capture mem_q into the owner's q register and pulse its q_valid on the next edge.
    - Write: no q_valid.
    - Clear the owner's pending flag and busy, return to ARB_IDLE.
- mem_addr/data/wstrb are held stable from the grant until ARB_DONE exits.
- Streak counter:
  - Increments on a video grant while CPU is pending.
  - Clears on any CPU grant, and on a video grant with no CPU pending.
  - Saturates at 15.
- A new request arriving during another port's transaction is captured and arbitrated on return to ARB_IDLE.
- Minimum read latency, request pulse to q_valid: capture + grant + issue + controller time + 1 edge.
- Port q registers hold their value until the next read completion for that port.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- Defined: dbg_cpu_grants and dbg_vid_grants are 16-bit wrapping counters, incremented on each ARB_IDLE grant to the respective port and cleared by reset.
- Undefined: both outputs are constant 0 and no counter logic exists.

Test Plan:
- Lone CPU read of addr 0x000100; controller model returns 0xDEADBEEF → exactly one mem_rd pulse with mem_addr 0x000100; cpu_q = 0xDEADBEEF; one cpu_q_valid pulse; vid_q_valid stays 0.
- CPU write of 0x12345678 with wstrb 4'b0101 → mem_wr pulse with mem_data/mem_wstrb matching; no cpu_q_valid; cpu_busy falls after mem_busy falls.
- cpu_rd and vid_rd pulsed in the same cycle → video is served first, then CPU; each q_valid carries its own address's data.
- Video pulses continuously re-requested while CPU is pending, STARVE_LIMIT = 4 → CPU is granted after exactly 4 video grants.
- Pulse on a busy port → ignored; exactly one mem transaction results.
- reset_n low during ARB_DONE → all outputs 0 immediately; no q_valid after release; a fresh request afterwards completes normally.
- With SRAM_ARB_STATS_EN: 3 CPU and 5 video transactions → counters read 3 and 5. Without the macro: both counters read 0.
